// File: rtl/p2_counter_ctrl.sv
// Sequencing controller for an 8-bit loadable counter register: clear, load, timed increments, wrap detect.
// Optional build macro P2_CTRL_AUTORELOAD_EN: after each wrap, reload the captured value and keep running.
module p2_counter_ctrl #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] init_val,
    input  logic             co,
    output logic             inz,
    output logic             inc,
    output logic             ld,
    output logic [WIDTH-1:0] ld_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   inc_count
);

    // state | meaning
    // IDLE  | waiting for start
    // CLEAR | inz strobe to the register
    // LOAD  | ld strobe with captured start value
    // RUN   | prescaled increment pulses until wrap
    // DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, DONE} state_t;

    localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [WIDTH:0]  CNT_MAX  = {1'b1, {WIDTH{1'b0}}};

    state_t        state;
    logic [PW-1:0] presc;

    assign inz  = (state == CLEAR);
    assign ld   = (state == LOAD);
    assign done = (state == DONE);
    assign inc  = (state == RUN) && (presc == PRE_LAST);
`ifdef P2_CTRL_AUTORELOAD_EN
    assign busy = (state != IDLE);
`else
    assign busy = (state == CLEAR) || (state == LOAD) || (state == RUN);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            presc     <= '0;
            ld_val    <= '0;
            inc_count <= '0;
        end else begin
            // inc is already on the register's pins, so it is counted even if abort lands with it
            if (inc && (inc_count != CNT_MAX))
                inc_count <= inc_count + 1'b1;
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            ld_val    <= init_val;
                            inc_count <= '0;
                            state     <= CLEAR;
                        end
                    end
                    CLEAR: state <= LOAD;
                    LOAD: begin
                        presc <= '0;
                        state <= RUN;
                    end
                    RUN: begin
                        presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
                        if (inc && co)
                            state <= DONE;
                    end
                    DONE: begin
`ifdef P2_CTRL_AUTORELOAD_EN
                        inc_count <= '0;
                        state     <= LOAD;
`else
                        state     <= IDLE;
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_p2_counter_ctrl.sv
// Bench for p2_counter_ctrl: two instances (TICK_DIV 1 and 4) driving behavioural counter registers.
module tb_p2_counter_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] start_v  = '0;
    logic [1:0] abort_v  = '0;
    logic [1:0] glitch_v = '0;
    logic [1:0] co_v, inz_v, inc_v, ld_v, busy_v, done_v;
    logic [1:0][7:0] init_v = '0;
    logic [1:0][7:0] ldv_v;
    logic [1:0][8:0] cnt_v;
    logic [1:0][7:0] reg_v = '0;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    p2_counter_ctrl #(.WIDTH(8), .TICK_DIV(1)) u_td1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .init_val(init_v[0]),
        .co(co_v[0]), .inz(inz_v[0]), .inc(inc_v[0]), .ld(ld_v[0]), .ld_val(ldv_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .inc_count(cnt_v[0]));

    p2_counter_ctrl #(.WIDTH(8), .TICK_DIV(4)) u_td4 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .init_val(init_v[1]),
        .co(co_v[1]), .inz(inz_v[1]), .inc(inc_v[1]), .ld(ld_v[1]), .ld_val(ldv_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .inc_count(cnt_v[1]));

    // Counter register being sequenced; glitch drives co high outside inc cycles
    assign co_v[0] = (reg_v[0] == 8'hFF) | glitch_v[0];
    assign co_v[1] = (reg_v[1] == 8'hFF) | glitch_v[1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (inz_v[i])      reg_v[i] <= 8'h00;
            else if (ld_v[i])  reg_v[i] <= ldv_v[i];
            else if (inc_v[i]) reg_v[i] <= reg_v[i] + 8'h01;
        end
    end

    // Expected {inz,ld,inc,done,busy} and inc_count for cycle c after start accepted at edge 0
    function automatic void exp_at(input int c, input int n, input int td,
                                   output logic [4:0] es, output int ec);
        int d;
        int p;
        int q;
        d  = 3 + n * td;
        p  = n * td + 2;
        es = '0;
        ec = 0;
        if (c <= d) begin
            es[4] = (c == 1);
            es[3] = (c == 2);
            es[2] = (c >= 3) && (c < d) && (((c - 3) % td) == td - 1);
            es[1] = (c == d);
            es[0] = (c < d);
`ifdef P2_CTRL_AUTORELOAD_EN
            es[0] = 1'b1;
`endif
            ec = (c >= 3) ? (c - 3) / td : 0;
        end else begin
`ifdef P2_CTRL_AUTORELOAD_EN
            q     = (c - d - 1) % p;
            es[3] = (q == 0);
            es[2] = (q >= 1) && (q <= n * td) && (((q - 1) % td) == td - 1);
            es[1] = (q == p - 1);
            es[0] = 1'b1;
            ec    = (q == 0) ? 0 : (q - 1) / td;
`else
            q  = 0;
            ec = n;
`endif
        end
    endfunction

    function automatic logic [4:0] strobes(input int sel);
        return {inz_v[sel], ld_v[sel], inc_v[sel], done_v[sel], busy_v[sel]};
    endfunction

    task automatic test_run(input int sel, input int v, input int ign_at, input bit nowait);
        int td;
        int n;
        int d;
        int last;
        int ec;
        logic [4:0] es;
        td = (sel == 1) ? 4 : 1;
        n  = 256 - v;
        d  = 3 + n * td;
`ifdef P2_CTRL_AUTORELOAD_EN
        last = d + 2 * (n * td + 2);
`else
        last = d + 1;
`endif
        if (!nowait) begin
            @(posedge clk); #1;
        end
        start_v[sel] = 1'b1;
        init_v[sel]  = v[7:0];
        @(posedge clk); #1;
        start_v[sel] = 1'b0;
        init_v[sel]  = 8'($urandom);
        for (int c = 1; c <= last; c++) begin
            exp_at(c, n, td, es, ec);
            glitch_v[sel] = es[2] ? 1'b0 : 1'($urandom);
            start_v[sel]  = (c == ign_at);
            @(negedge clk);
            checks++;
            if (strobes(sel) !== es) begin
                errs++;
                $display("FAIL run_strobes sel=%0d v=%0d c=%0d got=%b exp=%b", sel, v, c, strobes(sel), es);
            end
            checks++;
            if (cnt_v[sel] !== 9'(ec)) begin
                errs++;
                $display("FAIL run_inc_count sel=%0d v=%0d c=%0d got=%0d exp=%0d", sel, v, c, cnt_v[sel], ec);
            end
            checks++;
            if (ldv_v[sel] !== v[7:0]) begin
                errs++;
                $display("FAIL run_ld_val sel=%0d c=%0d got=%0d exp=%0d", sel, c, ldv_v[sel], v);
            end
            @(posedge clk); #1;
        end
        glitch_v[sel] = 1'b0;
        start_v[sel]  = 1'b0;
`ifdef P2_CTRL_AUTORELOAD_EN
        abort_v[sel] = 1'b1;
        @(posedge clk); #1;
        abort_v[sel] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (strobes(sel) !== 5'b0) begin
                errs++;
                $display("FAIL autoreload_abort sel=%0d got=%b exp=00000", sel, strobes(sel));
            end
            @(posedge clk); #1;
        end
`endif
    endtask

    task automatic test_reset();
        int v;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({strobes(i), ldv_v[i], cnt_v[i]} !== 22'd0) begin
                errs++;
                $display("FAIL reset_state sel=%0d got=%b/%0d/%0d exp=0", i, strobes(i), ldv_v[i], cnt_v[i]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        start_v[1] = 1'b1;
        init_v[1]  = 8'($urandom_range(0, 200));
        @(posedge clk); #1;
        start_v[1] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (busy_v[1] !== 1'b1 || cnt_v[1] !== 9'd1) begin
            errs++;
            $display("FAIL reset_prerun busy=%b cnt=%0d exp busy=1 cnt=1", busy_v[1], cnt_v[1]);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({strobes(1), ldv_v[1], cnt_v[1]} !== 22'd0) begin
            errs++;
            $display("FAIL reset_async got=%b/%0d/%0d exp=0", strobes(1), ldv_v[1], cnt_v[1]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        v = $urandom_range(200, 255);
        test_run(1, v, 0, 1'b1);
    endtask

    task automatic test_abort();
        int v;
        v = $urandom_range(0, 200);
        @(posedge clk); #1;
        start_v[1] = 1'b1;
        init_v[1]  = v[7:0];
        @(posedge clk); #1;
        start_v[1] = 1'b0;
        for (int c = 1; c < 15; c++) begin
            @(posedge clk); #1;
        end
        abort_v[1] = 1'b1;
        @(posedge clk); #1;
        abort_v[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (strobes(1) !== 5'b0 || cnt_v[1] !== 9'd3) begin
            errs++;
            $display("FAIL abort_idle got=%b cnt=%0d exp=00000 cnt=3", strobes(1), cnt_v[1]);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (done_v[1] !== 1'b0 || busy_v[1] !== 1'b0 || cnt_v[1] !== 9'd3) begin
                errs++;
                $display("FAIL abort_quiet c=%0d done=%b busy=%b cnt=%0d exp 0 0 3", c, done_v[1], busy_v[1], cnt_v[1]);
            end
        end
    endtask

    task automatic test_start_abort_idle();
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        init_v[0]  = 8'd77;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (strobes(0) !== 5'b0 || ldv_v[0] === 8'd77) begin
                errs++;
                $display("FAIL start_abort_idle c=%0d got=%b ld_val=%0d exp=00000 ld_val!=77", c, strobes(0), ldv_v[0]);
            end
        end
    endtask

    initial begin
        int sel;
        int v;
        test_reset();
        test_run(0, 250, 5, 1'b0);
        test_run(0, 255, 0, 1'b0);
        test_run(1, 0, 100, 1'b0);
        test_abort();
        test_start_abort_idle();
        test_run(0, 254, 3, 1'b0);
        test_run(0, 254, 0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            sel = $urandom_range(0, 1);
            v   = (sel == 1) ? $urandom_range(200, 255) : $urandom_range(100, 255);
            test_run(sel, v, 3 + $urandom_range(0, 2), 1'b0);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
